adder_measure_ctrl: RTL and testbench
=====================================

# adder_measure_ctrl

Measurement sequencer for the instrumented Kogge-Stone adder macro. Takes a measurement request from the logic-analyser registers, applies operands to the adder, checks the static sum, then enables the adder's ring-oscillator path for a programmed number of clock cycles. After the window it waits for the ring to settle, reads the macro's ring counter until the value is stable, and holds the results for readback. It sits between the LA-port register bank and the adder inside the project wrapper.

## Interface
- WIDTH, 32, operand, sum and ring-count width
- WIN_W, 24, window-length register width
- SETTLE_CYCLES, 4, wait cycles after each operand apply and after ring disable (≥2)
- MAX_READS, 16, capture reads before declaring the count unstable
- wb_clk_i  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  measurement request; acted on at its rising edge only
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- window  in  WIN_W  ring-enable length, in clock cycles
- adder_sum  in  WIDTH  static sum output of the adder macro
- ring_count  in  WIDTH  ring-domain counter; stable only after ring_en drops
- adder_a  out  WIDTH  registered operand A to the macro
- adder_b  out  WIDTH  registered operand B to the macro
- ring_en  out  1  closes the oscillation loop
- count_clr  out  1  clears the macro ring counter
- busy  out  1  high from acceptance through DONE
- done  out  1  one-cycle pulse when results are valid
- result_count  out  WIDTH  captured ring count
- sum_val  out  WIDTH  captured static sum
- sum_err  out  1  adder_sum differed from op_a+op_b mod 2^WIDTH
- unstable  out  1  ring_count failed to settle within MAX_READS reads

## Operation
- FSM states: IDLE, LOAD, RUN, SETTLE, CAPTURE, DONE.
- Start detection: start is registered once, and a rising edge = start & ~start_q. Edges outside IDLE are ignored and not queued.
- IDLE → LOAD on a start edge:
  - latch op_a, op_b, window;
  - drive adder_a/adder_b;
  - compute expected = op_a+op_b truncated to WIDTH.
- LOAD:
  - count_clr high and ring_en low for SETTLE_CYCLES cycles;
  - on the last cycle, capture adder_sum into sum_val and set sum_err = (adder_sum != expected).
  - Then → RUN, or → SETTLE directly if the latched window == 0.
- RUN: ring_en high for exactly window cycles, using a down-counter loaded with the latched window. Then → SETTLE.
- SETTLE: ring_en low for SETTLE_CYCLES cycles, then → CAPTURE.
- CAPTURE:
  - register ring_count once per cycle;
  - when two consecutive samples are equal, result_count = that sample, unstable = 0, → DONE;
  - after MAX_READS samples with no match, result_count = last sample, unstable = 1, → DONE.
- DONE: done high for one cycle, → IDLE. result_count, sum_val, sum_err and unstable hold until the next accepted start, which clears sum_err and unstable.
- window and operand inputs are sampled only at acceptance; later changes have no effect mid-measurement.

## Timing
- Reset values: all outputs 0, FSM in IDLE, start_q = 0. Asserting reset_n low mid-measurement drops ring_en and count_clr immediately (asynchronously).
- The start edge is seen the cycle after start rises. busy rises in the cycle after that and count_clr rises with it.
- adder_a/adder_b change in the same cycle busy rises.
- ring_en is high for exactly window clock cycles; no glitch on entry or exit; always 0 when window == 0.
- Total latency from accepted edge to done, with k = CAPTURE samples taken (2 ≤ k ≤ MAX_READS): SETTLE_CYCLES + window + SETTLE_CYCLES + k + 1 cycles.
- done and busy fall together. A new start edge is accepted no earlier than the cycle after DONE.
- window = 2^WIN_W−1 must not overflow the down-counter.

## Structure
- Shared package adder_meas_pkg holds:
  - the state enum;
  - the default SETTLE_CYCLES and MAX_READS;
  - the readback bit positions of sum_err, unstable, busy and done used by the LA register map.
- Sub-module: capture_stabilizer, which holds the sample register, the equality check and the read counter, with outputs match, timeout and value.
- Everything else (FSM, window counter, start edge detect, operand registers) lives in adder_measure_ctrl.

## Test plan
- Sum check, correct adder: op_a=0x0000_0005, op_b=0x0000_0003, adder_sum=0x8, window=0 → done after 4+0+4+2+1 = 11 cycles; sum_val=0x8, sum_err=0, ring_en never high, result_count=model value.
- Sum mismatch: op_a=0xFFFF_FFFF, op_b=0x1, adder_sum=0x1 → sum_err=1 (expected 0x0, wrap-around); sum_val=0x1.
- Ring window: window=100, ring_count model counts while ring_en is high then freezes at 0x1234 → ring_en high exactly 100 cycles; result_count=0x1234, unstable=0.
- Never-settling counter: ring_count increments every cycle → unstable=1 after 16 reads; result_count = 16th sample.
- Start abuse: start held high through the whole measurement, then pulsed during RUN → exactly one measurement; no second busy.
- Reset in RUN: reset_n low during cycle 50 of a window=100 run → ring_en, busy and all results 0 at once; a subsequent start runs a full 100-cycle window.

Source files
------------

// File: rtl/adder_meas_pkg.sv
// adder_meas_pkg: shared state encoding, default timing constants and LA readback bit map
package adder_meas_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } meas_state_e;
  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int MAX_READS_DEF     = 16;
  localparam int BIT_SUM_ERR       = 0;
  localparam int BIT_UNSTABLE      = 1;
  localparam int BIT_BUSY          = 2;
  localparam int BIT_DONE          = 3;
endpackage

// File: rtl/capture_stabilizer.sv
// capture_stabilizer: samples the ring counter each enabled cycle and flags two equal consecutive reads or read exhaustion
module capture_stabilizer #(
  parameter int WIDTH     = 32,
  parameter int MAX_READS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_sample,
  output logic             o_match,
  output logic             o_timeout,
  output logic [WIDTH-1:0] o_value
);
  localparam int CW = $clog2(MAX_READS + 1);
  logic [WIDTH-1:0] r_sample;
  logic [CW-1:0]    r_reads;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_reads  <= '0;
    end else if (!i_en) begin
      r_reads <= '0;
    end else begin
      r_sample <= i_sample;
      r_reads  <= r_reads + CW'(1);
    end
  end
  // the live input is the current read; r_reads counts reads already taken
  assign o_match   = i_en && (r_reads != '0) && (i_sample == r_sample);
  assign o_timeout = i_en && !o_match && (r_reads == CW'(MAX_READS - 1));
  assign o_value   = i_sample;
endmodule

// File: rtl/adder_measure_ctrl.sv
// adder_measure_ctrl: sequences operand apply, static sum check, timed ring-oscillator window and ring-count capture
module adder_measure_ctrl
  import adder_meas_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int WIN_W         = 24,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int MAX_READS     = MAX_READS_DEF
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIN_W-1:0] window,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic [WIDTH-1:0] ring_count,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             ring_en,
  output logic             count_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_count,
  output logic [WIDTH-1:0] sum_val,
  output logic             sum_err,
  output logic             unstable
);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
  meas_state_e      r_state, w_nxt;
  logic             r_start_q;
  logic [WIN_W-1:0] r_win, r_cnt;
  logic [WIDTH-1:0] r_expected, w_value;
  logic             w_start_edge, w_cnt_zero, w_match, w_timeout;
  assign w_start_edge = start & ~r_start_q;
  assign w_cnt_zero   = (r_cnt == '0);
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_nxt = w_start_edge ? ST_LOAD : ST_IDLE;
      ST_LOAD:    w_nxt = !w_cnt_zero ? ST_LOAD : (r_win == '0) ? ST_SETTLE : ST_RUN;
      ST_RUN:     w_nxt = w_cnt_zero ? ST_SETTLE : ST_RUN;
      ST_SETTLE:  w_nxt = w_cnt_zero ? ST_CAPTURE : ST_SETTLE;
      ST_CAPTURE: w_nxt = (w_match || w_timeout) ? ST_DONE : ST_CAPTURE;
      default:    w_nxt = ST_IDLE;
    endcase
  end
  // r_cnt holds remaining cycles minus one in the current timed state
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q    <= 1'b0;
      r_win        <= '0;
      r_cnt        <= '0;
      r_expected   <= '0;
      adder_a      <= '0;
      adder_b      <= '0;
      ring_en      <= 1'b0;
      count_clr    <= 1'b0;
      result_count <= '0;
      sum_val      <= '0;
      sum_err      <= 1'b0;
      unstable     <= 1'b0;
    end else begin
      r_start_q <= start;
      ring_en   <= (w_nxt == ST_RUN);
      count_clr <= (w_nxt == ST_LOAD);
      if (r_state != w_nxt) r_cnt <= (w_nxt == ST_RUN) ? r_win - WIN_W'(1) : SETTLE_LAST;
      else if (!w_cnt_zero) r_cnt <= r_cnt - WIN_W'(1);
      if (r_state == ST_IDLE && w_start_edge) begin
        r_win      <= window;
        adder_a    <= op_a;
        adder_b    <= op_b;
        r_expected <= op_a + op_b;
        sum_err    <= 1'b0;
        unstable   <= 1'b0;
      end
      if (r_state == ST_LOAD && w_cnt_zero) begin
        sum_val <= adder_sum;
        sum_err <= (adder_sum != r_expected);
      end
      if (r_state == ST_CAPTURE && (w_match || w_timeout)) begin
        result_count <= w_value;
        unstable     <= ~w_match;
      end
    end
  end
  capture_stabilizer #(.WIDTH(WIDTH), .MAX_READS(MAX_READS)) u_cap (
    .clk      (wb_clk_i),
    .rst_n    (reset_n),
    .i_en     (r_state == ST_CAPTURE),
    .i_sample (ring_count),
    .o_match  (w_match),
    .o_timeout(w_timeout),
    .o_value  (w_value)
  );
endmodule

// File: tb/tb_adder_measure_ctrl.sv
// tb_adder_measure_ctrl: randomized measurements against an arithmetic reference of sum check, latency, window and capture
module tb_adder_measure_ctrl;
  localparam int S  = 4;
  localparam int MR = 16;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [23:0] window = '0;
  logic [31:0] adder_sum, ring_count, adder_a, adder_b, result_count, sum_val;
  logic        ring_en, count_clr, busy, done, sum_err, unstable;
  int          n_checks = 0, n_errors = 0;
  bit          adder_bad = 1'b0, ring_run = 1'b0;
  int          ring_lag = 0, lag_cnt = 0;
  logic [31:0] ring_pre = '0, ring_q = '0;

  always #5 clk = ~clk;

  adder_measure_ctrl dut (
    .wb_clk_i(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .window(window), .adder_sum(adder_sum), .ring_count(ring_count),
    .adder_a(adder_a), .adder_b(adder_b), .ring_en(ring_en), .count_clr(count_clr),
    .busy(busy), .done(done), .result_count(result_count), .sum_val(sum_val),
    .sum_err(sum_err), .unstable(unstable)
  );

  // adder macro: correct sum, or LSB flipped when faulty
  assign adder_sum = (adder_a + adder_b) ^ {31'b0, adder_bad};
  // ring counter: counts while ring_en, for ring_lag cycles after, or always in runaway mode
  always @(posedge clk) begin
    lag_cnt <= ring_en ? ring_lag : (lag_cnt > 0 ? lag_cnt - 1 : 0);
    if (count_clr) ring_q <= ring_pre;
    else if (ring_run || ring_en || lag_cnt > 0) ring_q <= ring_q + 1;
  end
  assign ring_count = ring_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // value seen on capture read i is preset plus the number of counting cycles since the last clear
  task automatic predict(input int w, input int lag, input bit run, input logic [31:0] pre,
                         output int k, output logic [31:0] res, output bit unst);
    logic [31:0] prev, cur;
    int lp;
    lp = (w == 0) ? 0 : lag;
    prev = '0;
    k = MR; res = '0; unst = 1'b1;
    for (int i = 1; i <= MR; i++) begin
      cur = run ? pre + 32'(w + S + i - 1) : pre + 32'((w + lp < w + S + i - 1) ? w + lp : w + S + i - 1);
      if (i >= 2 && cur == prev) begin
        k = i; res = cur; unst = 1'b0;
        return;
      end
      prev = cur;
      res = cur;
    end
  endtask

  task automatic measure(input logic [31:0] a, input logic [31:0] b, input int w, input bit bad,
                         input logic [31:0] pre, input int lag, input bit run, input bit hold);
    int k, busy_n, ring_n, ring_rise, done_n, last_done, t, extra;
    logic [31:0] res, esum;
    bit unst, prev_ring;
    predict(w, lag, run, pre, k, res, unst);
    esum = a + b;
    adder_bad = bad; ring_pre = pre; ring_lag = lag; ring_run = run;
    @(posedge clk); #1;
    op_a = a; op_b = b; window = 24'(w); start = 1'b1;
    @(negedge clk);
    check("busy_before_accept", busy, 0);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    op_a = $urandom; op_b = $urandom; window = 24'($urandom_range(0, 7));
    @(negedge clk);
    check("busy_rise", busy, 1);
    check("count_clr_rise", count_clr, 1);
    check("adder_a", adder_a, a);
    check("adder_b", adder_b, b);
    check("flags_cleared", {sum_err, unstable}, 0);
    busy_n = 0; ring_n = 0; ring_rise = 0; done_n = 0; last_done = 0; t = 0; prev_ring = 0;
    while (busy && t < w + 200) begin
      busy_n++;
      ring_n += int'(ring_en);
      ring_rise += int'(ring_en && !prev_ring);
      prev_ring = ring_en;
      if (done) begin done_n++; last_done = busy_n; end
      if (hold && ring_n == 3) start = 1'b0;
      if (hold && ring_n == 5) start = 1'b1;
      @(negedge clk);
      t++;
    end
    check("busy_bounded", busy, 0);
    check("latency", busy_n, 2 * S + w + k + 1);
    check("done_once", done_n, 1);
    check("done_last_cycle", last_done, busy_n);
    check("ring_cycles", ring_n, w);
    check("ring_rises", ring_rise, (w > 0) ? 1 : 0);
    check("sum_val", sum_val, bad ? esum ^ 32'h1 : esum);
    check("sum_err", sum_err, bad);
    check("result_count", result_count, res);
    check("unstable", unstable, unst);
    check("done_low_after", done, 0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      extra += int'(busy);
    end
    check("no_second_run", extra, 0);
    check("results_hold", {sum_err, unstable, result_count}, {bad, unst, res});
    start = 1'b0;
  endtask

  initial begin
    int n, t;
    @(negedge clk);
    check("rst_busy_done", {busy, done, ring_en, count_clr}, 0);
    check("rst_data", {adder_a, adder_b, result_count, sum_val}, 0);
    check("rst_flags", {sum_err, unstable}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    measure(32'h5, 32'h3, 0, 0, 32'h55, 0, 0, 0);
    measure(32'hFFFF_FFFF, 32'h1, 0, 1, 32'h7, 0, 0, 0);
    measure($urandom, $urandom, 100, 0, 32'h1234 - 100, 0, 0, 0);
    measure($urandom, $urandom, 10, 0, 32'h0, 0, 1, 0);
    measure($urandom, $urandom, 100, 0, 32'h10, 2, 0, 1);
    measure($urandom, $urandom, 1, 0, 32'h20, 7, 0, 0);
    for (int i = 0; i < 8; i++)
      measure($urandom, $urandom, $urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 24), $urandom_range(0, 4) == 0, 0);
    // reset in the 50th cycle of a 100-cycle window
    ring_run = 1'b0; ring_lag = 0; adder_bad = 1'b0;
    @(posedge clk); #1;
    op_a = 32'h11; op_b = 32'h22; window = 24'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; t = 0;
    while (n < 49 && t < 300) begin
      @(negedge clk);
      n += int'(ring_en);
      t++;
    end
    check("reach_run_cycle_50", n, 49);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", {ring_en, count_clr, busy, done}, 0);
    check("async_rst_results", {result_count, sum_val, sum_err, unstable}, 0);
    check("async_rst_operands", {adder_a, adder_b}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    measure(32'h11, 32'h22, 100, 0, 32'h40, 3, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
